// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the two-requester FIFO write-port arbiter.
// The FSM state type is shared so the bench and the RTL use the same encoding.
package fifo_arb_pkg;

    localparam int unsigned NUM_REQ = 2;
    localparam int unsigned DATA_W  = 8;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StGrant = 1'b1
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write-port arbiter.
// The master modport is the environment: producers plus the FIFO full flag.
interface fifo_wr_arbiter_if;

    logic                              vld0;
    logic                              vld1;
    logic [fifo_arb_pkg::DATA_W-1:0]   din0;
    logic [fifo_arb_pkg::DATA_W-1:0]   din1;
    logic                              rdy0;
    logic                              rdy1;
    logic                              fifo_full;
    logic                              wr_en;
    logic [fifo_arb_pkg::DATA_W-1:0]   fifo_in;
    logic [fifo_arb_pkg::NUM_REQ-1:0]  gnt;
    logic                              busy;

    modport master (
        output vld0, vld1, din0, din1, fifo_full,
        input  rdy0, rdy1, wr_en, fifo_in, gnt, busy
    );

    modport slave (
        input  vld0, vld1, din0, din1, fifo_full,
        output rdy0, rdy1, wr_en, fifo_in, gnt, busy
    );

endinterface

// File: rtl/fifo_arb_rr.sv
// Round-robin winner selection for two requesters.
// The last winner is remembered so that a contested grant alternates.
module fifo_arb_rr (
    input  logic i_sysclk,
    input  logic i_rst_b,
    input  logic i_vld0,
    input  logic i_vld1,
    input  logic i_load,
    output logic o_winner
);

    logic r_last_id;
    logic w_winner;

    // A lone requester always wins; a contested grant goes to the one that did not win last.
    assign w_winner = (i_vld0 && i_vld1) ? ~r_last_id : i_vld1;
    assign o_winner = w_winner;

    // Reset to 1 so requester 0 takes the first contested grant.
    always_ff @(posedge i_sysclk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_last_id <= 1'b1;
        end else if (i_load) begin
            r_last_id <= w_winner;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Two-requester burst arbiter for the FIFO write port; never writes while the FIFO is full.
// Define FIFO_WR_ARB_STATS_EN to add the saturating per-requester accept counters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             i_sysclk,
    input  logic             i_rst_b,
    fifo_wr_arbiter_if.slave bus
`ifdef FIFO_WR_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] o_wcnt0,
    output logic [CNT_W-1:0] o_wcnt1
`endif
);

    localparam int unsigned          BCNT_W   = $clog2(BURST_LEN + 1);
    localparam logic [BCNT_W-1:0]    LAST_CNT = BCNT_W'(BURST_LEN - 1);

    if (BURST_LEN == 0 || BURST_LEN > 255 || CNT_W == 0) begin : g_param_check
        $error("fifo_wr_arbiter: BURST_LEN must be 1..255 and CNT_W nonzero");
    end

    arb_state_e          r_state;
    arb_state_e          w_state_nxt;
    logic [NUM_REQ-1:0]  r_gnt;
    logic [NUM_REQ-1:0]  w_gnt_nxt;
    logic [BCNT_W-1:0]   r_bcnt;
    logic [BCNT_W-1:0]   w_bcnt_nxt;
    logic                w_load;
    logic                w_winner;
    logic                w_busy;
    logic                w_vld_g;
    logic [DATA_W-1:0]   w_din_g;
    logic                w_accept;

    fifo_arb_rr u_rr (
        .i_sysclk (i_sysclk),
        .i_rst_b  (i_rst_b),
        .i_vld0   (bus.vld0),
        .i_vld1   (bus.vld1),
        .i_load   (w_load),
        .o_winner (w_winner)
    );

    assign w_busy   = (r_state == StGrant);
    assign w_vld_g  = r_gnt[1] ? bus.vld1 : bus.vld0;
    assign w_din_g  = r_gnt[1] ? bus.din1 : bus.din0;
    assign w_accept = w_busy & w_vld_g & ~bus.fifo_full;

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_bcnt_nxt  = r_bcnt;
        w_load      = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (bus.vld0 || bus.vld1) begin
                    w_state_nxt = StGrant;
                    w_gnt_nxt   = w_winner ? 2'b10 : 2'b01;
                    w_bcnt_nxt  = '0;
                    w_load      = 1'b1;
                end
            end
            StGrant: begin
                // Early release wins even when the FIFO is full in the same cycle.
                if (!w_vld_g) begin
                    w_state_nxt = StIdle;
                    w_gnt_nxt   = '0;
                end else if (w_accept) begin
                    w_bcnt_nxt = r_bcnt + 1'b1;
                    if (r_bcnt == LAST_CNT) begin
                        w_state_nxt = StIdle;
                        w_gnt_nxt   = '0;
                    end
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_sysclk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_state <= StIdle;
            r_gnt   <= '0;
            r_bcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_bcnt  <= w_bcnt_nxt;
        end
    end

    assign bus.wr_en   = w_accept;
    assign bus.rdy0    = w_accept & r_gnt[0];
    assign bus.rdy1    = w_accept & r_gnt[1];
    assign bus.fifo_in = w_busy ? w_din_g : '0;
    assign bus.gnt     = r_gnt;
    assign bus.busy    = w_busy;

`ifdef FIFO_WR_ARB_STATS_EN
    logic [CNT_W-1:0] r_wcnt0;
    logic [CNT_W-1:0] r_wcnt1;

    always_ff @(posedge i_sysclk or negedge i_rst_b) begin
        if (!i_rst_b) begin
            r_wcnt0 <= '0;
            r_wcnt1 <= '0;
        end else begin
            if (bus.rdy0 && (r_wcnt0 != '1)) begin
                r_wcnt0 <= r_wcnt0 + 1'b1;
            end
            if (bus.rdy1 && (r_wcnt1 != '1)) begin
                r_wcnt1 <= r_wcnt1 + 1'b1;
            end
        end
    end

    assign o_wcnt0 = r_wcnt0;
    assign o_wcnt1 = r_wcnt1;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle vector table plus reset and statistics sequences.
module tb_fifo_wr_arbiter;

    typedef struct {
        logic       rst_b;
        logic       vld0;
        logic       vld1;
        logic [7:0] din0;
        logic [7:0] din1;
        logic       full;
        logic       wr_en;
        logic [7:0] fifo_in;
        logic       rdy0;
        logic       rdy1;
        logic [1:0] gnt;
        logic       busy;
    } vec_t;

    logic clk;
    logic rst_b;
    int   n_checks;
    int   n_fail;
    vec_t vecs[$];

    fifo_wr_arbiter_if bus ();

`ifdef FIFO_WR_ARB_STATS_EN
    logic [3:0] wcnt0;
    logic [3:0] wcnt1;
`endif

    fifo_wr_arbiter #(
        .BURST_LEN (4),
        .CNT_W     (4)
    ) dut (
        .i_sysclk (clk),
        .i_rst_b  (rst_b),
        .bus      (bus)
`ifdef FIFO_WR_ARB_STATS_EN
        ,
        .o_wcnt0  (wcnt0),
        .o_wcnt1  (wcnt1)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic v(input logic r, input logic v0, input logic v1, input logic [7:0] d0,
                     input logic [7:0] d1, input logic f, input logic we, input logic [7:0] fi,
                     input logic r0, input logic r1, input logic [1:0] g, input logic b);
        vec_t x;
        x.rst_b = r;  x.vld0 = v0; x.vld1 = v1; x.din0 = d0; x.din1 = d1; x.full = f;
        x.wr_en = we; x.fifo_in = fi; x.rdy0 = r0; x.rdy1 = r1; x.gnt = g; x.busy = b;
        vecs.push_back(x);
    endtask

    task automatic drive(input logic r, input logic v0, input logic v1, input logic [7:0] d0,
                         input logic [7:0] d1, input logic f);
        rst_b = r; bus.vld0 = v0; bus.vld1 = v1; bus.din0 = d0; bus.din1 = d1; bus.fifo_full = f;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_outs(input string tag, input logic we, input logic [7:0] fi,
                            input logic r0, input logic r1, input logic [1:0] g, input logic b);
        chk({tag, " wr_en"}, 16'(bus.wr_en), 16'(we));
        chk({tag, " fifo_in"}, 16'(bus.fifo_in), 16'(fi));
        chk({tag, " rdy0"}, 16'(bus.rdy0), 16'(r0));
        chk({tag, " rdy1"}, 16'(bus.rdy1), 16'(r1));
        chk({tag, " gnt"}, 16'(bus.gnt), 16'(g));
        chk({tag, " busy"}, 16'(bus.busy), 16'(b));
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        repeat (2) @(posedge clk);
        #1;

        // Single requester: 11..44 in one burst, an idle cycle, then 55 in a new burst.
        v(0,0,0,8'h00,8'h00,0, 0,8'h00,0,0,2'b00,0);
        v(1,1,0,8'h11,8'h00,0, 0,8'h00,0,0,2'b00,0);
        v(1,1,0,8'h11,8'h00,0, 1,8'h11,1,0,2'b01,1);
        v(1,1,0,8'h22,8'h00,0, 1,8'h22,1,0,2'b01,1);
        v(1,1,0,8'h33,8'h00,0, 1,8'h33,1,0,2'b01,1);
        v(1,1,0,8'h44,8'h00,0, 1,8'h44,1,0,2'b01,1);
        v(1,1,0,8'h55,8'h00,0, 0,8'h00,0,0,2'b00,0);
        v(1,1,0,8'h55,8'h00,0, 1,8'h55,1,0,2'b01,1);
        v(1,0,0,8'h00,8'h00,0, 0,8'h00,0,0,2'b01,1);
        v(1,0,0,8'h00,8'h00,0, 0,8'h00,0,0,2'b00,0);
        // Both continuously valid: A0-A3, B0-B3, A4.
        v(0,0,0,8'h00,8'h00,0, 0,8'h00,0,0,2'b00,0);
        v(1,1,1,8'hA0,8'hB0,0, 0,8'h00,0,0,2'b00,0);
        v(1,1,1,8'hA0,8'hB0,0, 1,8'hA0,1,0,2'b01,1);
        v(1,1,1,8'hA1,8'hB0,0, 1,8'hA1,1,0,2'b01,1);
        v(1,1,1,8'hA2,8'hB0,0, 1,8'hA2,1,0,2'b01,1);
        v(1,1,1,8'hA3,8'hB0,0, 1,8'hA3,1,0,2'b01,1);
        v(1,1,1,8'hA4,8'hB0,0, 0,8'h00,0,0,2'b00,0);
        v(1,1,1,8'hA4,8'hB0,0, 1,8'hB0,0,1,2'b10,1);
        v(1,1,1,8'hA4,8'hB1,0, 1,8'hB1,0,1,2'b10,1);
        v(1,1,1,8'hA4,8'hB2,0, 1,8'hB2,0,1,2'b10,1);
        v(1,1,1,8'hA4,8'hB3,0, 1,8'hB3,0,1,2'b10,1);
        v(1,1,1,8'hA4,8'hB4,0, 0,8'h00,0,0,2'b00,0);
        v(1,1,1,8'hA4,8'hB4,0, 1,8'hA4,1,0,2'b01,1);
        // Three-cycle full stall mid-burst, then the burst completes 4 words.
        v(0,0,0,8'h00,8'h00,0, 0,8'h00,0,0,2'b00,0);
        v(1,1,0,8'h10,8'h00,0, 0,8'h00,0,0,2'b00,0);
        v(1,1,0,8'h10,8'h00,0, 1,8'h10,1,0,2'b01,1);
        v(1,1,0,8'h11,8'h00,0, 1,8'h11,1,0,2'b01,1);
        v(1,1,0,8'h12,8'h00,1, 0,8'h12,0,0,2'b01,1);
        v(1,1,0,8'h12,8'h00,1, 0,8'h12,0,0,2'b01,1);
        v(1,1,0,8'h12,8'h00,1, 0,8'h12,0,0,2'b01,1);
        v(1,1,0,8'h12,8'h00,0, 1,8'h12,1,0,2'b01,1);
        v(1,1,0,8'h13,8'h00,0, 1,8'h13,1,0,2'b01,1);
        v(1,0,0,8'h00,8'h00,0, 0,8'h00,0,0,2'b00,0);
        // Requester 1 drops after 2 words (FIFO full that cycle); requester 0 follows.
        v(0,0,0,8'h00,8'h00,0, 0,8'h00,0,0,2'b00,0);
        v(1,0,1,8'h00,8'hC0,0, 0,8'h00,0,0,2'b00,0);
        v(1,0,1,8'h00,8'hC0,0, 1,8'hC0,0,1,2'b10,1);
        v(1,0,1,8'h00,8'hC1,0, 1,8'hC1,0,1,2'b10,1);
        v(1,1,0,8'hD0,8'hC2,1, 0,8'hC2,0,0,2'b10,1);
        v(1,1,0,8'hD0,8'hC2,0, 0,8'h00,0,0,2'b00,0);
        v(1,1,0,8'hD0,8'hC2,0, 1,8'hD0,1,0,2'b01,1);

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst_b, vecs[i].vld0, vecs[i].vld1, vecs[i].din0, vecs[i].din1,
                  vecs[i].full);
            #1;
            chk_outs($sformatf("vec%0d", i), vecs[i].wr_en, vecs[i].fifo_in, vecs[i].rdy0,
                     vecs[i].rdy1, vecs[i].gnt, vecs[i].busy);
            tick();
        end

        // Reset mid-burst: outputs clear at once, and requester 0 wins first afterwards.
        drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
        tick();
        drive(1'b1, 1'b1, 1'b0, 8'h5A, 8'h00, 1'b0);
        tick();
        tick();
        #1;
        chk_outs("pre_rst", 1'b1, 8'h5A, 1'b1, 1'b0, 2'b01, 1'b1);
        rst_b = 1'b0;
        #1;
        chk_outs("in_rst", 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
        tick();
        chk_outs("held_rst", 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 8'h5A, 8'h6B, 1'b0);
        #1;
        chk_outs("post_rst_idle", 1'b0, 8'h00, 1'b0, 1'b0, 2'b00, 1'b0);
        tick();
        chk_outs("post_rst_gnt", 1'b1, 8'h5A, 1'b1, 1'b0, 2'b01, 1'b1);

`ifdef FIFO_WR_ARB_STATS_EN
        begin
            int n_acc;
            drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
            tick();
            chk("wcnt0 reset", 16'(wcnt0), 16'd0);
            drive(1'b1, 1'b1, 1'b0, 8'h77, 8'h00, 1'b0);
            n_acc = 0;
            for (int c = 0; c < 60 && n_acc < 20; c++) begin
                #1;
                if (bus.rdy0) n_acc++;
                tick();
            end
            chk("stats accepts", 16'(n_acc), 16'd20);
            bus.vld0 = 1'b0;
            tick();
            chk("wcnt0 saturated", 16'(wcnt0), 16'd15);
            chk("wcnt1 idle", 16'(wcnt1), 16'd0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
